// File: rtl/pwm_audio_pkg.sv
// Constants and state type shared by the PWM audio input and output blocks.
package pwm_audio_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_PERIOD = 255;

  typedef enum logic {
    ST_ALIGN = 1'b0,
    ST_RUN   = 1'b1
  } pwm_state_e;

endpackage

// File: rtl/pwm_duty_counter.sv
// One PWM channel: synchronizer, optional 3-tap majority filter (PWM_IN_GLITCH_FILTER_EN),
// rising-edge detector and per-frame high-cycle accumulator.
module pwm_duty_counter
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int PERIOD      = DEFAULT_PERIOD,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             din,
  input  logic             count_en,
  input  logic             frame_end,
  output logic             rise,
  output logic [WIDTH-1:0] sample
);

  localparam int ACC_W = $clog2(PERIOD + 1);
  localparam logic [31:0] SAT_MAX = 32'((64'd1 << WIDTH) - 64'd1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d, svld_q, svld_d;
  logic                   level, level_vld;
  logic                   prev_q, prev_d, pvld_q, pvld_d;
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [WIDTH-1:0]       sample_q, sample_d;
  logic [31:0]            sum;

  // A valid bit travels beside each data bit so the zeros loaded at reset
  // never look like a low-to-high transition on a line that is already high.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], din};
  assign svld_d = {svld_q[SYNC_STAGES-2:0], 1'b1};

`ifdef PWM_IN_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;
  logic       filt_q, filt_d;
  logic [2:0] fvld_q, fvld_d;
  logic       synced;

  assign synced    = sync_q[SYNC_STAGES-1];
  assign hist_d    = {hist_q[0], synced};
  assign filt_d    = (synced & hist_q[0]) | (synced & hist_q[1]) | (hist_q[0] & hist_q[1]);
  assign fvld_d    = {fvld_q[1:0], svld_q[SYNC_STAGES-1]};
  assign level     = filt_q;
  assign level_vld = fvld_q[2];

  always_ff @(posedge clk) begin
    if (aclr) begin
      hist_q <= '0;
      filt_q <= 1'b0;
      fvld_q <= '0;
    end else begin
      hist_q <= hist_d;
      filt_q <= filt_d;
      fvld_q <= fvld_d;
    end
  end
`else
  assign level     = sync_q[SYNC_STAGES-1];
  assign level_vld = svld_q[SYNC_STAGES-1];
`endif

  assign prev_d = level;
  assign pvld_d = level_vld;
  assign rise   = level & ~prev_q & pvld_q;
  assign sum    = 32'(acc_q) + 32'(level);
  assign sample = sample_q;

  always_comb begin
    acc_d    = acc_q;
    sample_d = sample_q;
    if (!count_en) begin
      acc_d = '0;
    end else if (frame_end) begin
      acc_d    = '0;
      sample_d = (sum > SAT_MAX) ? WIDTH'(SAT_MAX) : WIDTH'(sum);
    end else begin
      acc_d = acc_q + ACC_W'(level);
    end
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      sync_q   <= '0;
      svld_q   <= '0;
      prev_q   <= 1'b0;
      pvld_q   <= 1'b0;
      acc_q    <= '0;
      sample_q <= '0;
    end else begin
      sync_q   <= sync_d;
      svld_q   <= svld_d;
      prev_q   <= prev_d;
      pvld_q   <= pvld_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
    end
  end

endmodule

// File: rtl/pwm_audio_stereo_in.sv
// Stereo PWM audio decoder: aligns a shared frame counter to the incoming streams and
// emits both duty counts once per frame. Optional glitch filter: PWM_IN_GLITCH_FILTER_EN.
module pwm_audio_stereo_in
  import pwm_audio_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int PERIOD        = DEFAULT_PERIOD,
  parameter int SYNC_STAGES   = 2,
  parameter int ALIGN_TIMEOUT = 2 * PERIOD
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             left,
  input  logic             right,
  output logic [WIDTH-1:0] left_sample,
  output logic [WIDTH-1:0] right_sample,
  output logic             sample_valid,
  output logic             locked,
  output logic             run_dbg
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam int TMO_W = $clog2(ALIGN_TIMEOUT + 1);

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             locked_q, locked_d, valid_q, valid_d;
  logic             l_rise, r_rise, rise_any, go, count_en, frame_end;

  pwm_duty_counter #(.WIDTH(WIDTH), .PERIOD(PERIOD), .SYNC_STAGES(SYNC_STAGES)) u_left (
    .clk(clk), .aclr(aclr), .din(left), .count_en(count_en), .frame_end(frame_end),
    .rise(l_rise), .sample(left_sample)
  );

  pwm_duty_counter #(.WIDTH(WIDTH), .PERIOD(PERIOD), .SYNC_STAGES(SYNC_STAGES)) u_right (
    .clk(clk), .aclr(aclr), .din(right), .count_en(count_en), .frame_end(frame_end),
    .rise(r_rise), .sample(right_sample)
  );

  // The cycle that leaves ALIGN is frame cycle 0 and is already counted.
  assign rise_any  = l_rise | r_rise;
  assign go        = (state_q == ST_ALIGN) && (rise_any || (tmo_q == TMO_W'(ALIGN_TIMEOUT - 1)));
  assign count_en  = (state_q == ST_RUN) || go;
  assign frame_end = count_en && (cnt_q == CNT_W'(PERIOD - 1));

  // sample_valid is a one-cycle strobe with no back-pressure; both samples
  // change only on that cycle and hold their value until the next strobe.
  assign sample_valid = valid_q;
  assign locked       = locked_q;
  assign run_dbg      = (state_q == ST_RUN);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    valid_d  = frame_end;
    case (state_q)
      ST_ALIGN: begin
        tmo_d    = tmo_q + TMO_W'(1);
        cnt_d    = '0;
        locked_d = 1'b0;
        if (go) begin
          state_d  = ST_RUN;
          cnt_d    = CNT_W'(1);
          tmo_d    = '0;
          locked_d = rise_any;
        end
      end
      default: begin
        cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
        if (rise_any) locked_d = (cnt_q == '0);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      state_q  <= ST_ALIGN;
      cnt_q    <= '0;
      tmo_q    <= '0;
      locked_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      locked_q <= locked_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_pwm_audio_stereo_in.sv
// Bench for pwm_audio_stereo_in: whole-segment PWM streams, a sequence-level reference
// model filling an expected queue, and a strobe-driven monitor.
module tb_pwm_audio_stereo_in;

  localparam int WIDTH  = 8;
  localparam int PERIOD = 255;
  localparam int SYNC   = 2;
  localparam int TMO    = 2 * PERIOD;
`ifdef PWM_IN_GLITCH_FILTER_EN
  localparam int FLT = 3;
`else
  localparam int FLT = 0;
`endif
  localparam int MAXN = 2048;
  localparam int EW   = 2 * WIDTH + 1;
  localparam int SAT  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             aclr = 1'b1;
  logic             left = 1'b0;
  logic             right = 1'b0;
  logic [WIDTH-1:0] left_sample, right_sample;
  logic             sample_valid, locked, run_dbg;

  int               n_checks = 0;
  int               n_errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_e;
  int               xl[MAXN];
  int               xr[MAXN];
  int               duty_l[16];
  int               duty_r[16];
  int               a;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  pwm_audio_stereo_in #(
    .WIDTH(WIDTH), .PERIOD(PERIOD), .SYNC_STAGES(SYNC), .ALIGN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .aclr(aclr), .left(left), .right(right),
    .left_sample(left_sample), .right_sample(right_sample),
    .sample_valid(sample_valid), .locked(locked), .run_dbg(run_dbg)
  );

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // ---------------- reference model ----------------
  // Input level seen after the synchronizer; zero before any input has arrived.
  function automatic int syn(input int ch, input int k);
    int j;
    j = k - SYNC;
    if (j < 0 || j >= MAXN) return 0;
    return (ch == 0) ? xl[j] : xr[j];
  endfunction

  function automatic int lvl(input int ch, input int m);
`ifdef PWM_IN_GLITCH_FILTER_EN
    return ((syn(ch, m - 1) + syn(ch, m - 2) + syn(ch, m - 3)) >= 2) ? 1 : 0;
`else
    return syn(ch, m);
`endif
  endfunction

  // An edge needs two genuine consecutive samples (nothing from before the stream).
  function automatic int rise(input int m);
    if (m - 1 < SYNC + FLT) return 0;
    return ((lvl(0, m) == 1 && lvl(0, m - 1) == 0) ||
            (lvl(1, m) == 1 && lvl(1, m - 1) == 0)) ? 1 : 0;
  endfunction

  function automatic int find_align();
    for (int m = 0; m < TMO; m++) if (rise(m) != 0) return m;
    return TMO - 1;
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  // Every complete frame inside [0, n) produces one strobe.
  function automatic void build_expect(input int n);
    int al, lk, sl, sr, ph;
    logic [WIDTH-1:0] l8, r8;
    al = find_align();
    lk = 0; sl = 0; sr = 0;
    for (int m = al; m < n; m++) begin
      ph = (m - al) % PERIOD;
      if (rise(m) != 0) lk = (ph == 0) ? 1 : 0;
      sl += lvl(0, m);
      sr += lvl(1, m);
      if (ph == PERIOD - 1) begin
        l8 = WIDTH'(sat(sl));
        r8 = WIDTH'(sat(sr));
        exp_q.push_back({lk[0], l8, r8});
        sl = 0; sr = 0;
      end
    end
  endfunction

  // ---------------- stimulus builders ----------------
  function automatic void set_duty(input int dl, input int dr);
    for (int f = 0; f < 16; f++) begin
      duty_l[f] = dl;
      duty_r[f] = dr;
    end
  endfunction

  function automatic void rand_duty();
    for (int f = 0; f < 16; f++) begin
      duty_l[f] = $urandom_range(0, SAT);
      duty_r[f] = $urandom_range(0, SAT);
    end
    duty_l[0] = $urandom_range(1, 254);
  endfunction

  function automatic void fill_pwm(input int off);
    int f, ph;
    for (int k = 0; k < MAXN; k++) begin
      if (k < off) begin
        xl[k] = 0;
        xr[k] = 0;
      end else begin
        f  = (k - off) / PERIOD;
        ph = (k - off) % PERIOD;
        xl[k] = (ph < duty_l[f]) ? 1 : 0;
        xr[k] = (ph < duty_r[f]) ? 1 : 0;
      end
    end
  endfunction

  function automatic void fill_noise();
    for (int k = 0; k < MAXN; k++) begin
      xl[k] = $urandom_range(0, 1);
      xr[k] = $urandom_range(0, 1);
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset(input string tag);
    aclr  = 1'b1;
    left  = 1'b0;
    right = 1'b0;
    @(negedge clk);
    chk({tag, "_rst_left"}, int'(left_sample), 0);
    chk({tag, "_rst_right"}, int'(right_sample), 0);
    chk({tag, "_rst_valid"}, int'(sample_valid), 0);
    chk({tag, "_rst_locked"}, int'(locked), 0);
    chk({tag, "_rst_run"}, int'(run_dbg), 0);
    exp_q.delete();
    aclr = 1'b0;
  endtask

  task automatic drive_segment(input string tag, input int n);
    build_expect(n);
    for (int m = 0; m < n; m++) begin
      left  = (xl[m] != 0);
      right = (xr[m] != 0);
      @(negedge clk);
    end
    #1;
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_run"}, int'(run_dbg), 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (sample_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("left_sample", int'(left_sample), int'(mon_e[2*WIDTH-1:WIDTH]));
        chk("right_sample", int'(right_sample), int'(mon_e[WIDTH-1:0]));
        chk("locked", int'(locked), int'(mon_e[EW-1]));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    set_duty(127, 0);
    fill_pwm($urandom_range(3, 60));
    a = find_align();
    do_reset("pwm127");
    drive_segment("pwm127", a + 4 * PERIOD);

    set_duty(0, 0);
    fill_pwm(0);
    do_reset("zero");
    drive_segment("zero", (TMO - 1) + 3 * PERIOD);

    set_duty(PERIOD, PERIOD);
    fill_pwm(0);
    do_reset("high");
    drive_segment("high", (TMO - 1) + 3 * PERIOD);

    for (int r = 0; r < 2; r++) begin
      rand_duty();
      fill_pwm($urandom_range(3, 60));
      a = find_align();
      do_reset("rand");
      drive_segment("rand", a + 4 * PERIOD);
    end

    set_duty(127, 0);
    fill_pwm(10);
    xl[10 + 2 * PERIOD + 200] = 1;
    a = find_align();
    do_reset("glitch");
    drive_segment("glitch", a + 4 * PERIOD);

    rand_duty();
    fill_pwm($urandom_range(3, 60));
    a = find_align();
    do_reset("midrst");
    drive_segment("midrst", a + PERIOD + 100);
    do_reset("midrst_after");

    set_duty(127, $urandom_range(1, 200));
    fill_pwm($urandom_range(3, 60));
    a = find_align();
    drive_segment("relock", a + 3 * PERIOD);

    fill_noise();
    a = find_align();
    do_reset("noise");
    drive_segment("noise", a + 3 * PERIOD);

    do_reset("final");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pwm_audio_stereo_in.md
PWM_AUDIO_STEREO_IN -- requirements
Module: pwm_audio_stereo_in

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving sample width in bits.
REQ-002 SHALL have parameter PERIOD, default 255, giving PWM frame length in clk cycles; legal range 2..2**WIDTH-1.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the input synchronizer depth; minimum 2.
REQ-004 SHALL have parameter ALIGN_TIMEOUT, default 2*PERIOD, giving the cycles spent in ALIGN before a forced lock.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 aclr  input  1  reset, synchronous and active-high.
REQ-007 left  input  1  asynchronous left-channel PWM stream.
REQ-008 right  input  1  asynchronous right-channel PWM stream.
REQ-009 left_sample  output  WIDTH  last decoded left duty count.
REQ-010 right_sample  output  WIDTH  last decoded right duty count.
REQ-011 sample_valid  output  1  one-cycle strobe: both samples updated together.
REQ-012 locked  output  1  high while in RUN with frame timing aligned to the stream.

Function
REQ-013 SHALL pass each input through SYNC_STAGES flops; "synced" below means the last stage.
REQ-014 SHALL implement states ALIGN and RUN; ALIGN is entered from reset.
REQ-015 ALIGN: frame counter held at 0; accumulators held at 0; timeout counter increments each cycle.
REQ-016 ALIGN->RUN on a synced rising edge of left or right (low last cycle, high this cycle); that cycle becomes frame cycle 0 and its input level is counted.
REQ-017 ALIGN->RUN also when the timeout counter reaches ALIGN_TIMEOUT-1 (constant 0 or constant high stream); locked stays 0 after a forced lock until a rising edge lands on frame cycle 0.
REQ-018 RUN: frame counter counts 0..PERIOD-1 and wraps to 0.
REQ-019 RUN: each channel accumulator adds its synced level every cycle; accumulator width SHALL hold PERIOD without overflow.
REQ-020 At frame cycle PERIOD-1, sample SHALL be loaded with accumulator plus the current level, saturated to 2**WIDTH-1; accumulator restarts at 0 next cycle; sample_valid is high exactly in the cycle following.
REQ-021 locked SHALL be set when a rising edge is seen on frame cycle 0, and cleared when a rising edge on left or right is seen on any other frame cycle.
REQ-022 A rising edge on a nonzero frame cycle SHALL NOT realign the counter; realignment only via reset.
REQ-023 Simultaneous left and right rising edges in ALIGN count as one alignment event.
REQ-024 Input-to-sample latency: SYNC_STAGES cycles plus frame end; no output changes in ALIGN.

Reset
REQ-025 aclr high on a clock edge SHALL force: state ALIGN, all counters and accumulators 0, synchronizer flops 0, left_sample 0, right_sample 0, sample_valid 0, locked 0.
REQ-026 Reset mid-frame SHALL discard the partial frame; no sample_valid for it.
REQ-027 aclr dominates every other event in the same cycle.

Configuration
REQ-028 With PWM_IN_GLITCH_FILTER_EN defined, each synced input SHALL pass through a 3-tap majority filter (adds 2 cycles latency, rejects 1-cycle pulses) before edge detection and counting.
REQ-029 Without PWM_IN_GLITCH_FILTER_EN, synced inputs SHALL feed edge detection and counting directly.

Structure
REQ-030 Shared package pwm_audio_pkg SHALL hold default WIDTH/PERIOD constants and the ALIGN/RUN state typedef, shared with pwm_audio_stereo_out.
REQ-031 Per-channel synchronizer, optional filter, edge detector and accumulator SHALL be sub-module pwm_duty_counter, instantiated twice; frame counter and state machine stay in the top.

Verification
REQ-032 Stream from pwm_audio_stereo_out with left_top=127, right_top=0 -> after lock, every sample_valid shows left_sample=127, right_sample=0, locked=1, strobe every 255 cycles.
REQ-033 left_top=0, right_top=0 -> forced lock after 510 cycles, locked=0, samples 0.
REQ-034 Both inputs held high -> forced lock, samples saturate to 255 each frame, locked=0.
REQ-035 aclr pulsed at frame cycle 100 -> all outputs 0 next cycle, no strobe for that frame, relock on next rising edge.
REQ-036 left_top=127 with 1-cycle high glitch at frame cycle 200 -> locked drops to 0 and left_sample=128 without PWM_IN_GLITCH_FILTER_EN; locked stays 1 and left_sample=127 with it.
